// File: rtl/maze_pixel_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : maze_pixel_scanner
//  Description : 640x480@60 VGA timing generator for the maze display path.
//                Produces pixel strobe, x/y counters, syncs, video_on,
//                the current maze cell index and a frame-start strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module maze_pixel_scanner #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int COLS      = 3,
    parameter int ROWS      = 3,
    parameter int CELL_W    = 214,
    parameter int CELL_H    = 160
) (
    input  logic       clk,
    input  logic       reset,        // asynchronous, active-low
    output logic       pixel_tick,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [1:0] cell_col,
    output logic [1:0] cell_row,
    output logic       frame_start
);

    localparam int HSUB_W = $clog2(CELL_W);
    localparam int VSUB_W = $clog2(CELL_H);

    localparam logic [9:0] c_H_LAST     = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] c_V_LAST     = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] c_H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] c_V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] c_HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [1:0] c_COL_LAST   = 2'(COLS - 1);
    localparam logic [1:0] c_ROW_LAST   = 2'(ROWS - 1);
    localparam logic [HSUB_W-1:0] c_HSUB_LAST = HSUB_W'(CELL_W - 1);
    localparam logic [VSUB_W-1:0] c_VSUB_LAST = VSUB_W'(CELL_H - 1);

    // State registers
    logic              r_div;
    logic              r_tick;
    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic [HSUB_W-1:0] r_hsub;
    logic [VSUB_W-1:0] r_vsub;
    logic [1:0]        r_col;
    logic [1:0]        r_row;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_von;
    logic              r_fs;

    // Next-state values
    logic              w_adv;
    logic              w_x_wrap;
    logic              w_y_wrap;
    logic [9:0]        w_x_nxt;
    logic [9:0]        w_y_nxt;
    logic [HSUB_W-1:0] w_hsub_nxt;
    logic [VSUB_W-1:0] w_vsub_nxt;
    logic [1:0]        w_col_nxt;
    logic [1:0]        w_row_nxt;
    logic              w_hsync_nxt;
    logic              w_vsync_nxt;
    logic              w_von_nxt;

    // Position counters: x steps on every pixel, y steps on each x wrap
    always_comb begin
        w_adv    = r_div;
        w_x_wrap = w_adv && (r_x == c_H_LAST);
        w_y_wrap = w_x_wrap && (r_y == c_V_LAST);
        w_x_nxt  = r_x;
        w_y_nxt  = r_y;
        if (w_adv) begin
            w_x_nxt = w_x_wrap ? 10'd0 : r_x + 10'd1;
        end
        if (w_x_wrap) begin
            w_y_nxt = w_y_wrap ? 10'd0 : r_y + 10'd1;
        end
    end

    // Horizontal cell tracking; a line wrap beats a cell boundary, last column saturates
    always_comb begin
        w_hsub_nxt = r_hsub;
        w_col_nxt  = r_col;
        if (w_x_wrap) begin
            w_hsub_nxt = '0;
            w_col_nxt  = 2'd0;
        end else if (w_adv) begin
            if (r_hsub == c_HSUB_LAST) begin
                w_hsub_nxt = '0;
                if (r_col < c_COL_LAST) begin
                    w_col_nxt = r_col + 2'd1;
                end
            end else begin
                w_hsub_nxt = r_hsub + 1'b1;
            end
        end
    end

    // Vertical cell tracking; steps once per line, frame wrap beats a cell boundary
    always_comb begin
        w_vsub_nxt = r_vsub;
        w_row_nxt  = r_row;
        if (w_y_wrap) begin
            w_vsub_nxt = '0;
            w_row_nxt  = 2'd0;
        end else if (w_x_wrap) begin
            if (r_vsub == c_VSUB_LAST) begin
                w_vsub_nxt = '0;
                if (r_row < c_ROW_LAST) begin
                    w_row_nxt = r_row + 2'd1;
                end
            end else begin
                w_vsub_nxt = r_vsub + 1'b1;
            end
        end
    end

    // Decode from next-state counters so syncs/video_on line up with x_pos/y_pos
    always_comb begin
        w_hsync_nxt = !((w_x_nxt >= c_HS_FIRST) && (w_x_nxt <= c_HS_LAST));
        w_vsync_nxt = !((w_y_nxt >= c_VS_FIRST) && (w_y_nxt <= c_VS_LAST));
        w_von_nxt   = (w_x_nxt < c_H_VIS) && (w_y_nxt < c_V_VIS);
    end

    // Register all state; asynchronous clear to the idle (0,0) position
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div   <= 1'b0;
            r_tick  <= 1'b0;
            r_x     <= 10'd0;
            r_y     <= 10'd0;
            r_hsub  <= '0;
            r_vsub  <= '0;
            r_col   <= 2'd0;
            r_row   <= 2'd0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_von   <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_div   <= ~r_div;
            r_tick  <= r_div;          // strobe on the divider's 1->0 edge
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_hsub  <= w_hsub_nxt;
            r_vsub  <= w_vsub_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_hsync <= w_hsync_nxt;
            r_vsync <= w_vsync_nxt;
            r_von   <= w_von_nxt;
            r_fs    <= w_y_wrap;       // both counters land on (0,0)
        end
    end

    assign pixel_tick  = r_tick;
    assign x_pos       = r_x;
    assign y_pos       = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_von;
    assign cell_col    = r_col;
    assign cell_row    = r_row;
    assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_maze_pixel_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maze_pixel_scanner
//  Description : Self-checking bench. Instance A uses the default 640x480
//                timing; instance B uses a shrunken raster so whole frames
//                fit in a short run. Expected outputs come from an
//                arithmetic model of pixel position versus clock count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_pixel_scanner;

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic [1:0] cc;
        logic [1:0] cr;
        logic       fs;
    } pix_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #10 clk = ~clk;

    logic       a_tick, a_hs, a_vs, a_von, a_fs;
    logic [9:0] a_x, a_y;
    logic [1:0] a_cc, a_cr;
    logic       b_tick, b_hs, b_vs, b_von, b_fs;
    logic [9:0] b_x, b_y;
    logic [1:0] b_cc, b_cr;

    maze_pixel_scanner u_dut_a (
        .clk(clk), .reset(rst_a), .pixel_tick(a_tick), .x_pos(a_x), .y_pos(a_y),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .cell_col(a_cc),
        .cell_row(a_cr), .frame_start(a_fs)
    );

    maze_pixel_scanner #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .COLS(3), .ROWS(3), .CELL_W(6), .CELL_H(5)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .pixel_tick(b_tick), .x_pos(b_x), .y_pos(b_y),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .cell_col(b_cc),
        .cell_row(b_cr), .frame_start(b_fs)
    );

    pix_t obs_a, obs_b;
    assign obs_a = {a_tick, a_x, a_y, a_hs, a_vs, a_von, a_cc, a_cr, a_fs};
    assign obs_b = {b_tick, b_x, b_y, b_hs, b_vs, b_von, b_cc, b_cr, b_fs};

    // Clock edges seen since each reset release
    int ka = 0;
    int kb = 0;
    always @(posedge clk or negedge rst_a) if (!rst_a) ka <= 0; else ka <= ka + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) kb <= 0; else kb <= kb + 1;

    int ntests = 0;
    int nfail  = 0;

    // Expected outputs after k clock edges: pixel index = k/2, position by div/mod
    function automatic pix_t model(input int k,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb,
                                   input int cols, input int cw, input int rows, input int ch);
        pix_t e;
        int htot, vtot, p, x, y, c, r;
        e = '0;
        if (k == 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            return e;
        end
        htot  = hd + hf + hsw + hb;
        vtot  = vd + vf + vsw + vb;
        p     = k / 2;
        x     = p % htot;
        y     = (p / htot) % vtot;
        c     = (x / cw > cols - 1) ? cols - 1 : x / cw;
        r     = (y / ch > rows - 1) ? rows - 1 : y / ch;
        e.tick = (k % 2 == 0);
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.hs   = !(x >= hd + hf && x < hd + hf + hsw);
        e.vs   = !(y >= vd + vf && y < vd + vf + vsw);
        e.von  = (x < hd) && (y < vd);
        e.cc   = 2'(c);
        e.cr   = 2'(r);
        e.fs   = e.tick && (x == 0) && (y == 0);
        return e;
    endfunction

    function automatic pix_t mdl_a(input int k);
        return model(k, 640, 16, 96, 48, 480, 10, 2, 33, 3, 214, 3, 160);
    endfunction

    function automatic pix_t mdl_b(input int k);
        return model(k, 16, 2, 3, 3, 12, 2, 2, 2, 3, 6, 3, 5);
    endfunction

    task automatic test_reset();
        pix_t e;
        e = mdl_a(0);
        repeat (2) begin
            @(negedge clk);
            ntests++;
            if (obs_a !== e) begin
                nfail++;
                $display("FAIL reset_a: got %h want %h", obs_a, e);
            end
            ntests++;
            if (obs_b !== e) begin
                nfail++;
                $display("FAIL reset_b: got %h want %h", obs_b, e);
            end
        end
    endtask

    // Release A and follow the first few clocks edge by edge
    task automatic test_startup();
        pix_t e;
        rst_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            e = mdl_a(ka);
            ntests++;
            if (obs_a !== e) begin
                nfail++;
                $display("FAIL startup k=%0d: got %h want %h", ka, obs_a, e);
            end
        end
    endtask

    // Two full lines on A: model match plus line period, hsync width, cell sweep
    task automatic test_line();
        pix_t e;
        int   last_x0 = -1;
        int   hs_fall = -1;
        logic prev_hs = 1'b1;
        logic prev_von;
        int   cx[6]  = '{213, 214, 427, 428, 799, 0};
        int   cce[6] = '{0, 1, 1, 2, 2, 0};
        prev_von = a_von;
        for (int i = 0; i < 3300; i++) begin
            @(negedge clk);
            e = mdl_a(ka);
            ntests++;
            if (obs_a !== e) begin
                nfail++;
                if (nfail < 40) $display("FAIL line k=%0d: got %h want %h", ka, obs_a, e);
            end
            if (a_tick && a_x == 10'd0) begin
                if (last_x0 >= 0) begin
                    ntests++;
                    if (ka - last_x0 != 1600) begin
                        nfail++;
                        $display("FAIL line_period: got %0d want 1600", ka - last_x0);
                    end
                end
                last_x0 = ka;
            end
            if (!a_hs && prev_hs) begin
                hs_fall = ka;
                ntests++;
                if (a_x !== 10'd656) begin
                    nfail++;
                    $display("FAIL hsync_start_x: got %0d want 656", a_x);
                end
            end
            if (a_hs && !prev_hs && hs_fall >= 0) begin
                ntests++;
                if (ka - hs_fall != 192) begin
                    nfail++;
                    $display("FAIL hsync_width: got %0d want 192", ka - hs_fall);
                end
            end
            if (!a_von && prev_von && a_y < 10'd480) begin
                ntests++;
                if (a_x !== 10'd640) begin
                    nfail++;
                    $display("FAIL video_off_x: got %0d want 640", a_x);
                end
            end
            for (int j = 0; j < 6; j++) begin
                if (a_tick && int'(a_x) == cx[j] && a_y == 10'd0) begin
                    ntests++;
                    if (int'(a_cc) != cce[j]) begin
                        nfail++;
                        $display("FAIL cell_col x=%0d: got %0d want %0d", cx[j], a_cc, cce[j]);
                    end
                end
            end
            prev_hs  = a_hs;
            prev_von = a_von;
        end
    endtask

    // Three frames on the small raster: frame period, vsync width, frame_start pulses
    task automatic test_frame();
        pix_t e;
        int   fs_cnt = 0;
        int   last_fs = -1;
        int   vs_low = 0;
        logic prev_fs = 1'b0;
        logic prev_vs = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 2700; i++) begin
            @(negedge clk);
            e = mdl_b(kb);
            ntests++;
            if (obs_b !== e) begin
                nfail++;
                if (nfail < 40) $display("FAIL frame k=%0d: got %h want %h", kb, obs_b, e);
            end
            if (fs_cnt == 1 && !b_vs) vs_low++;
            if (!b_vs && prev_vs) begin
                ntests++;
                if (b_y !== 10'd14) begin
                    nfail++;
                    $display("FAIL vsync_start_y: got %0d want 14", b_y);
                end
            end
            if (b_fs) begin
                ntests++;
                if (prev_fs) begin
                    nfail++;
                    $display("FAIL fs_width: got 2+ clks want 1");
                end
                if (last_fs >= 0) begin
                    ntests++;
                    if (kb - last_fs != 864) begin
                        nfail++;
                        $display("FAIL frame_period: got %0d want 864", kb - last_fs);
                    end
                end
                if (fs_cnt == 1) begin
                    ntests++;
                    if (vs_low != 96) begin
                        nfail++;
                        $display("FAIL vsync_width: got %0d want 96", vs_low);
                    end
                end
                fs_cnt++;
                last_fs = kb;
            end
            prev_fs = b_fs;
            prev_vs = b_vs;
        end
        ntests++;
        if (fs_cnt != 3) begin
            nfail++;
            $display("FAIL fs_count: got %0d want 3", fs_cnt);
        end
    endtask

    // Random run length, then reset asserted between edges and a clean restart
    task automatic test_async_reset(input bit sel, input int max_run);
        pix_t e, o;
        int   n;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(max_run, 40);
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                e = sel ? mdl_b(kb) : mdl_a(ka);
                o = sel ? obs_b : obs_a;
                ntests++;
                if (o !== e) begin
                    nfail++;
                    if (nfail < 40) $display("FAIL run%0d sel=%0d: got %h want %h", it, sel, o, e);
                end
            end
            #($urandom_range(6, 2));
            if (sel) rst_b = 1'b0; else rst_a = 1'b0;
            #1;
            e = mdl_a(0);
            o = sel ? obs_b : obs_a;
            ntests++;
            if (o !== e) begin
                nfail++;
                $display("FAIL async_reset sel=%0d: got %h want %h", sel, o, e);
            end
            repeat ($urandom_range(3, 1)) @(negedge clk);
            if (sel) rst_b = 1'b1; else rst_a = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                e = sel ? mdl_b(kb) : mdl_a(ka);
                o = sel ? obs_b : obs_a;
                ntests++;
                if (o !== e) begin
                    nfail++;
                    $display("FAIL restart sel=%0d k=%0d: got %h want %h", sel, i, o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_line();
        test_frame();
        test_async_reset(1'b0, 1500);
        test_async_reset(1'b1, 2000);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maze_pixel_scanner.md
Name: maze_pixel_scanner

Overview:
- Pixel-timing producer for the maze display path: generates 640x480@60 Hz VGA timing from the 50 MHz board clock.
- Drives the `x_pos`/`y_pos`/`video_on`/`hsync`/`vsync` signals consumed by the maze renderer.
- Also outputs the current maze cell index (`cell_col`, `cell_row`) from running sub-counters, so the renderer needs no divide or compare against cell boundaries.
- Also outputs per-pixel and per-frame strobes for the renderer's colour/path update logic.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- COLS, 3, maze columns
- ROWS, 3, maze rows
- CELL_W, 214, pixels per cell column
- CELL_H, 160, lines per cell row

Ports:
- clk  input  1  50 MHz system clock
- reset  input  1  asynchronous, active-low reset
- pixel_tick  output  1  one-clk strobe, every 2nd clk (25 MHz pixel rate)
- x_pos  output  10  horizontal counter, 0..H_total-1 (H_total = 800)
- y_pos  output  10  vertical counter, 0..V_total-1 (V_total = 525)
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- video_on  output  1  high when x_pos < H_DISPLAY and y_pos < V_DISPLAY
- cell_col  output  2  maze column index for the current pixel
- cell_row  output  2  maze row index for the current pixel
- frame_start  output  1  one-clk strobe when counters wrap to (0,0)

Behaviour:
- Reset (reset = 0, asynchronous): all state clears immediately, regardless of clock.
  - Tick divider = 0; x_pos = y_pos = 0; cell sub-counters = 0; cell_col = cell_row = 0.
  - hsync = vsync = 1; video_on = 0; pixel_tick = 0; frame_start = 0.
- Tick divider: 1-bit register toggling every clk.
  - pixel_tick is registered, and is 1 on the clk edge where the divider goes 1->0.
  - First pixel_tick is high in the 2nd clk cycle after reset deasserts; thereafter every 2 clks.
- Counter advance: only on cycles where the divider is 1 (the edge that raises pixel_tick).
  - x_pos: increments; wraps H_total-1 -> 0.
  - y_pos: increments only when x_pos wraps; wraps V_total-1 -> 0.
- Decode outputs (hsync, vsync, video_on) are registered from the next-state counter values, so they are always aligned with x_pos/y_pos.
  - One clk after reset release: video_on = 1 (position (0,0)), hsync = vsync = 1.
- hsync = 0 iff H_DISPLAY+H_FRONT <= x_pos <= H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
- vsync = 0 iff V_DISPLAY+V_FRONT <= y_pos <= V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491.
- Cell tracking, horizontal (sub-counter hsub, width ceil(log2(CELL_W))):
  - On x advance: if x wraps, hsub = 0 and cell_col = 0.
  - Else if hsub == CELL_W-1: hsub = 0, and cell_col increments only while cell_col < COLS-1 (saturates).
  - Else hsub increments.
  - Consequence: the last column absorbs the remainder. With defaults, col 2 covers x 428..639.
  - cell_col holds at COLS-1 through horizontal blanking.
- Cell tracking, vertical: identical rule using vsub/CELL_H/ROWS.
  - Advances only on x wrap; clears on y wrap.
- frame_start: 1 for exactly one clk, coincident with the pixel_tick cycle in which x_pos and y_pos both become 0.
  - Never asserts out of reset; the first assertion is at the first natural wrap.
- Simultaneous events:
  - x wrap and y wrap on the same tick: both counters and all four cell registers clear.
  - Cell boundary coinciding with a line wrap: the wrap takes priority.
- Width rules: all counters unsigned. Comparisons use full 10-bit values; no truncation.
- Parameter legality: COLS*CELL_W >= H_DISPLAY and ROWS*CELL_H >= V_DISPLAY. Otherwise behaviour is undefined and is not tested.

Test Plan:
- Reset release at t0 -> pixel_tick high at clks 2,4,6,…; x_pos reads 1 after clk 2 and 2 after clk 4; video_on = 1 from clk 1; frame_start stays 0.
- Run one line -> line period 1600 clks; hsync low for exactly 192 consecutive clks starting when x_pos = 656; video_on falls when x_pos = 640.
- Run full frame -> frame period 840000 clks; vsync low for 3200 clks starting at y_pos = 490; exactly one frame_start pulse per frame, 1 clk wide, at (0,0).
- Sweep line 0 -> cell_col: 0 at x = 213, 1 at x = 214, 1 at x = 427, 2 at x = 428, still 2 at x = 799, 0 at next x = 0.
  - Same sweep for cell_row: 0 at y = 159, 1 at y = 160, 2 at y = 320, 2 at y = 524, 0 after wrap.
- Assert reset mid-line (x_pos = 300, y_pos = 100), between clk edges -> all outputs take reset values immediately.
  - After release, the sequence restarts exactly as in scenario 1.
- Check video_on/cell consistency -> video_on = 0 for every x_pos >= 640 or y_pos >= 480.
  - Within the visible area, (cell_col, cell_row) always matches floor(x/214) and floor(y/160), each clipped to 2.
